// File: rtl/mapper_mem_arbiter.sv
// rtl/mapper_mem_arbiter.sv - single-outstanding PRG/CHR arbiter onto one shared memory port
//
// Grants one requester at a time onto the shared memory port. The memory returns read
// data a fixed MEM_LAT cycles after the command cycle. The arbiter captures that data and
// pulses the owner's ack for one cycle. Ties between PRG and CHR alternate round-robin.
//
// Optional feature macro: MEM_ARB_LOADER_EN adds a write-only loader channel (ld_*).
// The loader channel has absolute priority and does not disturb the round-robin state.
//
// Ports:
//   clk, reset                                      clock, async active-high reset
//   prg_req/prg_we/prg_addr/prg_wdata  -> prg_ack/prg_rdata   CPU-side channel
//   chr_req/chr_we/chr_addr/chr_wdata  -> chr_ack/chr_rdata   PPU-side channel
//   ld_req/ld_addr/ld_wdata            -> ld_ack              loader (MEM_ARB_LOADER_EN only)
//   mem_ready/mem_rdata                                 memory accept-ready and read data
//   mem_cmd/mem_we/mem_addr/mem_wdata                   registered memory command
module mapper_mem_arbiter #(
    parameter int MEM_LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        prg_req,
    input  logic        prg_we,
    input  logic [21:0] prg_addr,
    input  logic [7:0]  prg_wdata,
    output logic        prg_ack,
    output logic [7:0]  prg_rdata,
    input  logic        chr_req,
    input  logic        chr_we,
    input  logic [21:0] chr_addr,
    input  logic [7:0]  chr_wdata,
    output logic        chr_ack,
    output logic [7:0]  chr_rdata,
`ifdef MEM_ARB_LOADER_EN
    input  logic        ld_req,
    input  logic [21:0] ld_addr,
    input  logic [7:0]  ld_wdata,
    output logic        ld_ack,
`endif
    input  logic        mem_ready,
    input  logic [7:0]  mem_rdata,
    output logic        mem_cmd,
    output logic        mem_we,
    output logic [21:0] mem_addr,
    output logic [7:0]  mem_wdata
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {OWN_PRG, OWN_CHR, OWN_LD} owner_t;

    localparam logic [3:0] LAT4 = 4'(MEM_LAT);

    state_t      state_q;
    owner_t      owner_q;
    logic [3:0]  cnt_q;
    logic        last_chr_q;     // 1: CHR was granted last, so PRG wins the next tie
    logic        mem_cmd_q;
    logic        mem_we_q;
    logic [21:0] mem_addr_q;
    logic [7:0]  mem_wdata_q;
    logic        prg_ack_q;
    logic        chr_ack_q;
    logic [7:0]  prg_rdata_q;
    logic [7:0]  chr_rdata_q;
`ifdef MEM_ARB_LOADER_EN
    logic        ld_ack_q;
`endif

    // Winner selection for the current cycle; only acted on in S_IDLE.
    logic        grant_d;
    owner_t      owner_d;
    logic        we_d;
    logic [21:0] addr_d;
    logic [7:0]  wdata_d;

    always_comb begin
        grant_d = 1'b0;
        owner_d = OWN_PRG;
        we_d    = 1'b0;
        addr_d  = 22'd0;
        wdata_d = 8'd0;
`ifdef MEM_ARB_LOADER_EN
        if (ld_req) begin
            grant_d = 1'b1;
            owner_d = OWN_LD;
            we_d    = 1'b1;
            addr_d  = ld_addr;
            wdata_d = ld_wdata;
        end else
`endif
        if (prg_req && (!chr_req || last_chr_q)) begin
            grant_d = 1'b1;
            owner_d = OWN_PRG;
            we_d    = prg_we;
            addr_d  = prg_addr;
            wdata_d = prg_wdata;
        end else if (chr_req) begin
            grant_d = 1'b1;
            owner_d = OWN_CHR;
            we_d    = chr_we;
            addr_d  = chr_addr;
            wdata_d = chr_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_PRG;
            cnt_q       <= 4'd0;
            last_chr_q  <= 1'b1;
            mem_cmd_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 22'd0;
            mem_wdata_q <= 8'd0;
            prg_ack_q   <= 1'b0;
            chr_ack_q   <= 1'b0;
            prg_rdata_q <= 8'd0;
            chr_rdata_q <= 8'd0;
`ifdef MEM_ARB_LOADER_EN
            ld_ack_q    <= 1'b0;
`endif
        end else begin
            mem_cmd_q <= 1'b0;
            prg_ack_q <= 1'b0;
            chr_ack_q <= 1'b0;
`ifdef MEM_ARB_LOADER_EN
            ld_ack_q  <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (grant_d && mem_ready) begin
                        mem_cmd_q   <= 1'b1;
                        mem_we_q    <= we_d;
                        mem_addr_q  <= addr_d;
                        mem_wdata_q <= wdata_d;
                        owner_q     <= owner_d;
                        cnt_q       <= LAT4;
                        state_q     <= S_WAIT;
                        if (owner_d == OWN_PRG) begin
                            last_chr_q <= 1'b0;
                        end else if (owner_d == OWN_CHR) begin
                            last_chr_q <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    // cnt_q hits 0 exactly in the cycle the memory drives read data.
                    if (cnt_q == 4'd0) begin
                        state_q <= S_DONE;
                        case (owner_q)
                            OWN_PRG: begin
                                prg_rdata_q <= mem_rdata;
                                prg_ack_q   <= 1'b1;
                            end
                            OWN_CHR: begin
                                chr_rdata_q <= mem_rdata;
                                chr_ack_q   <= 1'b1;
                            end
                            default: begin
`ifdef MEM_ARB_LOADER_EN
                                ld_ack_q <= 1'b1;
`endif
                            end
                        endcase
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_cmd   = mem_cmd_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign prg_ack   = prg_ack_q;
    assign chr_ack   = chr_ack_q;
    assign prg_rdata = prg_rdata_q;
    assign chr_rdata = chr_rdata_q;
`ifdef MEM_ARB_LOADER_EN
    assign ld_ack    = ld_ack_q;
`endif

endmodule

// File: tb/tb_mapper_mem_arbiter.sv
// tb/tb_mapper_mem_arbiter.sv - randomized scoreboard bench for mapper_mem_arbiter
module tb_mapper_mem_arbiter;

    localparam int LAT = 3;
    localparam int PRG = 0;
    localparam int CHR = 1;
    localparam int LD  = 2;
    localparam int ST_IDLE  = 0;
    localparam int ST_PEND  = 1;
    localparam int ST_GRANT = 2;
`ifdef MEM_ARB_LOADER_EN
    localparam int NCH = 3;
`else
    localparam int NCH = 2;
`endif

    typedef struct { int cyc; logic we; logic [21:0] addr; logic [7:0] wdata; } cmd_t;
    typedef struct { int cyc; int ch; logic we; logic [7:0] data; } ack_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req [3];
    logic        we [3];
    logic [21:0] addr [3];
    logic [7:0]  wdata [3];
    logic        mem_ready;
    logic [7:0]  mem_rdata;
    logic        prg_ack, chr_ack, ld_ack;
    logic [7:0]  prg_rdata, chr_rdata;
    logic        mem_cmd, mem_we;
    logic [21:0] mem_addr;
    logic [7:0]  mem_wdata;

    mapper_mem_arbiter #(.MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .prg_req(req[0]), .prg_we(we[0]), .prg_addr(addr[0]), .prg_wdata(wdata[0]),
        .prg_ack(prg_ack), .prg_rdata(prg_rdata),
        .chr_req(req[1]), .chr_we(we[1]), .chr_addr(addr[1]), .chr_wdata(wdata[1]),
        .chr_ack(chr_ack), .chr_rdata(chr_rdata),
`ifdef MEM_ARB_LOADER_EN
        .ld_req(req[2]), .ld_addr(addr[2]), .ld_wdata(wdata[2]), .ld_ack(ld_ack),
`endif
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_cmd(mem_cmd), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
    );
`ifndef MEM_ARB_LOADER_EN
    assign ld_ack = 1'b0;
`endif

    always #5 clk = ~clk;

    // Reference model state
    cmd_t       cmd_q [$];
    ack_t       ack_q [$];
    logic [7:0] mem_model [logic [21:0]];
    logic [7:0] rdata_at [int];
    int         st [3];
    int         ack_cyc [3];
    int         free_cyc = 0;
    bit         last_chr = 1'b1;
    int         stall_left = 0;

    int vectors = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a command or an ack.
    cmd_t       ce;
    ack_t       ae;
    int         n_ack;
    int         ch_seen;
    logic [7:0] exp_prg_rd, exp_chr_rd;
    bit         prg_known, chr_known;

    always @(negedge clk) begin
        if (reset) begin
            exp_prg_rd = 8'd0;
            exp_chr_rd = 8'd0;
            prg_known  = 1'b1;
            chr_known  = 1'b1;
        end else if (mon_en) begin
            if (mem_cmd) begin
                if (cmd_q.size() == 0) begin
                    check("unexpected_mem_cmd", 32'(mem_cmd), 32'd0);
                end else begin
                    ce = cmd_q.pop_front();
                    check("cmd_cycle", cyc, ce.cyc);
                    check("cmd_we", 32'(mem_we), 32'(ce.we));
                    check("cmd_addr", 32'(mem_addr), 32'(ce.addr));
                    check("cmd_wdata", 32'(mem_wdata), 32'(ce.wdata));
                end
            end
            while (cmd_q.size() > 0 && cmd_q[0].cyc < cyc) begin
                check("missing_mem_cmd", 32'(mem_cmd), 32'd1);
                void'(cmd_q.pop_front());
            end

            n_ack = int'(prg_ack) + int'(chr_ack) + int'(ld_ack);
            if (n_ack > 1) check("ack_onehot", n_ack, 32'd1);
            if (n_ack != 0) begin
                ch_seen = prg_ack ? PRG : (chr_ack ? CHR : LD);
                if (ack_q.size() == 0) begin
                    check("unexpected_ack", 32'({ld_ack, chr_ack, prg_ack}), 32'd0);
                end else begin
                    ae = ack_q.pop_front();
                    check("ack_cycle", cyc, ae.cyc);
                    check("ack_channel", ch_seen, ae.ch);
                    if (ae.ch == PRG) begin
                        if (ae.we) prg_known = 1'b0;
                        else begin prg_known = 1'b1; exp_prg_rd = ae.data; end
                    end else if (ae.ch == CHR) begin
                        if (ae.we) chr_known = 1'b0;
                        else begin chr_known = 1'b1; exp_chr_rd = ae.data; end
                    end
                end
            end
            while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
                check("missing_ack", 32'({ld_ack, chr_ack, prg_ack}), 32'(1 << ack_q[0].ch));
                void'(ack_q.pop_front());
            end
            if (prg_known) check("prg_rdata", 32'(prg_rdata), 32'(exp_prg_rd));
            if (chr_known) check("chr_rdata", 32'(chr_rdata), 32'(exp_chr_rd));
        end
    end

    // Arbitration rules applied to the requests visible at this cycle's sampling edge.
    task automatic model_cycle();
        int         w;
        logic [7:0] d;
        if (cyc >= free_cyc && mem_ready) begin
            w = -1;
            if (st[LD] == ST_PEND) w = LD;
            else if (st[PRG] == ST_PEND && st[CHR] == ST_PEND) w = last_chr ? PRG : CHR;
            else if (st[PRG] == ST_PEND) w = PRG;
            else if (st[CHR] == ST_PEND) w = CHR;
            if (w >= 0) begin
                d = mem_model.exists(addr[w]) ? mem_model[addr[w]] : (addr[w][7:0] ^ 8'h5A);
                cmd_q.push_back('{cyc + 1, we[w], addr[w], wdata[w]});
                if (we[w]) mem_model[addr[w]] = wdata[w];
                else rdata_at[cyc + 1 + LAT] = d;
                ack_q.push_back('{cyc + LAT + 2, w, we[w], d});
                ack_cyc[w] = cyc + LAT + 2;
                st[w]      = ST_GRANT;
                free_cyc   = cyc + LAT + 3;
                if (w == PRG) last_chr = 1'b0;
                else if (w == CHR) last_chr = 1'b1;
            end
        end
        mem_rdata = rdata_at.exists(cyc) ? rdata_at[cyc] : 8'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drive_cycle(input bit allow_new);
        if (stall_left > 0) begin
            stall_left--;
            mem_ready = 1'b0;
        end else if (allow_new && $urandom_range(0, 11) == 0) begin
            stall_left = $urandom_range(0, 19);
            mem_ready  = 1'b0;
        end else begin
            mem_ready = 1'b1;
        end
        for (int ch = 0; ch < NCH; ch++) begin
            if (st[ch] == ST_GRANT && cyc > ack_cyc[ch]) begin
                st[ch]  = ST_IDLE;
                req[ch] = 1'b0;
            end
            case (st[ch])
                ST_IDLE: begin
                    if (allow_new && $urandom_range(0, (ch == LD) ? 30 : 3) == 0) begin
                        req[ch]   = 1'b1;
                        we[ch]    = (ch == LD) ? 1'b1 : 1'($urandom_range(0, 1));
                        addr[ch]  = 22'h08000 | 22'($urandom_range(0, 15));
                        wdata[ch] = 8'($urandom);
                        st[ch]    = ST_PEND;
                    end
                end
                ST_PEND: begin
                    if ($urandom_range(0, 15) == 0) begin
                        req[ch] = 1'b0;
                        st[ch]  = ST_IDLE;
                    end
                end
                default: begin
                    if ($urandom_range(0, 7) == 0) req[ch] = 1'b0;
                end
            endcase
        end
        model_cycle();
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (i < 300 && (cmd_q.size() + ack_q.size() > 0 || st[0] != ST_IDLE ||
                           st[1] != ST_IDLE || st[2] != ST_IDLE)) begin
            tick();
            drive_cycle(1'b0);
            i++;
        end
        check("drain_pending", 32'(cmd_q.size() + ack_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_cmd"}, 32'(mem_cmd), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_acks"}, 32'({ld_ack, chr_ack, prg_ack}), 32'd0);
        check({tag, "_prg_rdata"}, 32'(prg_rdata), 32'd0);
        check({tag, "_chr_rdata"}, 32'(chr_rdata), 32'd0);
    endtask

    initial begin
        for (int ch = 0; ch < 3; ch++) begin
            req[ch] = 1'b0; we[ch] = 1'b0; addr[ch] = 22'd0; wdata[ch] = 8'd0;
            st[ch] = ST_IDLE; ack_cyc[ch] = 0;
        end
        mem_ready = 1'b1;
        mem_rdata = 8'd0;
        #1 reset = 1'b1;
        #1 check_all_zero("reset");
        repeat (3) tick();
        reset  = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 1500; i++) begin
            tick();
            drive_cycle(1'b1);
        end
        stall_left = 0;
        drain();

        // Reset in the middle of a PRG read: everything clears and no ack follows.
        tick();
        req[PRG] = 1'b1; we[PRG] = 1'b0; addr[PRG] = 22'h08000; wdata[PRG] = 8'h00;
        st[PRG] = ST_PEND;
        mem_ready = 1'b1;
        model_cycle();
        tick(); model_cycle();
        tick(); model_cycle();
        #1 reset = 1'b1;
        #1 check_all_zero("midwait_reset");
        cmd_q.delete();
        ack_q.delete();
        rdata_at.delete();
        for (int ch = 0; ch < 3; ch++) begin
            req[ch] = 1'b0;
            st[ch]  = ST_IDLE;
        end
        last_chr = 1'b1;
        free_cyc = 0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            drive_cycle(1'b0);
        end

        for (int i = 0; i < 400; i++) begin
            tick();
            drive_cycle(1'b1);
        end
        stall_left = 0;
        drain();
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
